if_fetch_stage: RTL and testbench

Instruction-fetch stage for the 5-stage MIPS pipeline, directly upstream of the IF/ID stage register. It owns the PC, drives a variable-latency instruction-memory request/acknowledge interface, and presents PCPlus4F/Instr to IF/ID. It honours hazard-unit stalls (StallF) and branch/jump redirects from ID (PCSrcD/JumpD). While no instruction is available it emits NOP bubbles.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_next_pc.sv | 23 ++
 rtl/if_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC candidates: sequential PC+4 and the word-aligned redirect target.
// A jump wins over a taken branch when both arrive together.
module if_next_pc
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [31:0] pc_branch,
  input  logic [31:0] pc_jump,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_plus4
);

  // Pure selection; the increment wraps modulo 2^32 naturally.
  always_comb begin
    redirect = pc_src | jump;
    target   = word_align(jump ? pc_jump : pc_branch);
    pc_plus4 = pc + PC_INC;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake with
// instruction memory and presents PCPlus4F/Instr to the IF/ID register.
// FETCH passes ack data straight through; HOLD parks a fetched word while
// the hazard unit stalls; DRAIN waits out a request that was made stale by
// a redirect, because the request may not be withdrawn before its ack.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] Instr,
  output logic        InstrValidF,
  output logic        FetchBusyF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic [31:0]  drain_addr_q, drain_addr_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;

  logic         req_int;
  logic [31:0]  instr_int;
  logic         valid_int;
  logic         busy_int;

  if_next_pc u_next_pc (
    .pc        (pc_q),
    .pc_src    (PCSrcD),
    .jump      (JumpD),
    .pc_branch (PCBranchD),
    .pc_jump   (PCJumpD),
    .redirect  (redirect),
    .target    (target),
    .pc_plus4  (pc_plus4)
  );

  // State, PC and buffer registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      ibuf_q       <= 32'h0000_0000;
      drain_addr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_q       <= ibuf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state and memory/IF-ID outputs; redirect outranks StallF.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ibuf_d       = ibuf_q;
    drain_addr_d = drain_addr_q;
    req_int      = 1'b0;
    imem_addr    = pc_q;
    instr_int    = NOP_INSTR;
    valid_int    = 1'b0;
    busy_int     = 1'b0;

    case (state_q)
      FETCH: begin
        req_int   = 1'b1;
        imem_addr = pc_q;
        busy_int  = ~imem_ack;
        if (imem_ack) begin
          instr_int = imem_rdata;
          valid_int = 1'b1;
        end
        if (imem_ack && redirect) begin
          // Fetched word is on the wrong path; IF/ID flushes it.
          pc_d = target;
        end else if (!imem_ack && redirect) begin
          // Request stays on the bus until acked; park its address.
          drain_addr_d = pc_q;
          pc_d         = target;
          state_d      = DRAIN;
        end else if (imem_ack && StallF) begin
          ibuf_d  = imem_rdata;
          state_d = HOLD;
        end else if (imem_ack) begin
          pc_d = pc_plus4;
        end
      end

      HOLD: begin
        instr_int = ibuf_q;
        valid_int = 1'b1;
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        req_int   = 1'b1;
        imem_addr = drain_addr_q;
        busy_int  = 1'b1;
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          // Stale data is dropped; StallF does not hold us here.
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    PCF         = pc_q;
    PCPlus4F    = pc_plus4;
    imem_req    = rst_n & req_int;
    Instr       = rst_n ? instr_int : NOP_INSTR;
    InstrValidF = rst_n & valid_int;
    FetchBusyF  = rst_n & busy_int;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed cycle-by-cycle stimulus, expected
// per-cycle outputs pushed to a scoreboard queue and popped at the negedge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF;
  logic        PCSrcD;
  logic        JumpD;
  logic [31:0] PCBranchD;
  logic [31:0] PCJumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] Instr;
  logic        InstrValidF;
  logic        FetchBusyF;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEE1;

  typedef struct packed {
    logic [31:0] pcf;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        valid;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  int          num_checks = 0;
  int          num_errors = 0;
  logic [31:0] pc;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallF      (StallF),
    .PCSrcD      (PCSrcD),
    .JumpD       (JumpD),
    .PCBranchD   (PCBranchD),
    .PCJumpD     (PCJumpD),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .Instr       (Instr),
    .InstrValidF (InstrValidF),
    .FetchBusyF  (FetchBusyF)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pcf, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic valid, input logic busy);
    exp_t e;
    e.pcf = pcf; e.req = req; e.addr = addr; e.instr = instr; e.valid = valid; e.busy = busy;
    return e;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic src, input logic jmp,
                       input logic [31:0] br, input logic [31:0] jt,
                       input logic ack, input logic [31:0] rdata);
    rst_n = rst; StallF = stall; PCSrcD = src; JumpD = jmp;
    PCBranchD = br; PCJumpD = jt; imem_ack = ack; imem_rdata = rdata;
  endtask

  // One transaction: expectation queued with the stimulus, compared mid-cycle.
  task automatic run_cycle(input string tag, input exp_t e);
    exp_t x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check_eq({tag, ".PCF"}, PCF, x.pcf);
    check_eq({tag, ".PCPlus4F"}, PCPlus4F, x.pcf + 32'd4);
    check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, x.req});
    if (x.req) check_eq({tag, ".addr"}, imem_addr, x.addr);
    check_eq({tag, ".Instr"}, Instr, x.instr);
    check_eq({tag, ".valid"}, {31'd0, InstrValidF}, {31'd0, x.valid});
    check_eq({tag, ".busy"}, {31'd0, FetchBusyF}, {31'd0, x.busy});
    $display("%-6s PCF=%h req=%b addr=%h Instr=%h v=%b busy=%b",
             tag, PCF, imem_req, imem_addr, Instr, InstrValidF, FetchBusyF);
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetches from the bench-tracked pc; rdata = addr | 1.
  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1, pc | 32'd1);
      run_cycle(tag, mk(pc, 1, pc, pc | 32'd1, 1, 0));
      pc = pc + 32'd4;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, JUNK);
    repeat (2) @(posedge clk);
    #1;
    run_cycle("rst", mk(32'h0, 0, 32'h0, NOP, 0, 0));

    // 1: zero-wait streaming 0,4,8,C
    pc = 32'h0;
    stream("t1", 4);

    // 2: three-cycle latency at 0x10
    drive(1, 0, 0, 0, 0, 0, 0, JUNK);
    run_cycle("t2w0", mk(32'h10, 1, 32'h10, NOP, 0, 1));
    run_cycle("t2w1", mk(32'h10, 1, 32'h10, NOP, 0, 1));
    drive(1, 0, 0, 0, 0, 0, 1, 32'h11);
    run_cycle("t2ack", mk(32'h10, 1, 32'h10, 32'h11, 1, 0));
    pc = 32'h14;
    stream("t2s", 3);

    // 3: stall coinciding with ack at 0x20
    drive(1, 1, 0, 0, 0, 0, 1, 32'h8C00_0004);
    run_cycle("t3ack", mk(32'h20, 1, 32'h20, 32'h8C00_0004, 1, 0));
    drive(1, 1, 0, 0, 0, 0, 0, JUNK);
    run_cycle("t3hld", mk(32'h20, 0, 32'h20, 32'h8C00_0004, 1, 0));
    drive(1, 0, 0, 0, 0, 0, 0, JUNK);
    run_cycle("t3rel", mk(32'h20, 0, 32'h20, 32'h8C00_0004, 1, 0));
    pc = 32'h24;
    stream("t3s", 7);

    // 4: branch while 0x40 unacked -> drain, then fetch 0x100
    drive(1, 0, 1, 0, 32'h100, 0, 0, JUNK);
    run_cycle("t4br", mk(32'h40, 1, 32'h40, NOP, 0, 1));
    drive(1, 0, 0, 0, 0, 0, 0, JUNK);
    run_cycle("t4dr", mk(32'h100, 1, 32'h40, NOP, 0, 1));
    drive(1, 1, 0, 0, 0, 0, 1, 32'h41);
    run_cycle("t4dack", mk(32'h100, 1, 32'h40, NOP, 0, 1));
    pc = 32'h100;
    stream("t4s", 1);

    // 5: branch and jump together -> jump target, aligned
    drive(1, 0, 1, 1, 32'h200, 32'h303, 1, 32'h105);
    run_cycle("t5", mk(32'h104, 1, 32'h104, 32'h105, 1, 0));
    pc = 32'h300;
    stream("t5s", 1);

    // redirect in DRAIN on the ack cycle -> newest target, back to FETCH
    drive(1, 0, 0, 1, 0, 32'h400, 0, JUNK);
    run_cycle("t5j", mk(32'h304, 1, 32'h304, NOP, 0, 1));
    drive(1, 0, 1, 0, 32'h500, 0, 1, 32'h305);
    run_cycle("t5dr", mk(32'h400, 1, 32'h304, NOP, 0, 1));
    pc = 32'h500;
    stream("t5s2", 1);

    // 6: wrap at 0xFFFFFFFC, then reset mid-DRAIN
    drive(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 1, 32'h505);
    run_cycle("t6j", mk(32'h504, 1, 32'h504, 32'h505, 1, 0));
    pc = 32'hFFFF_FFFC;
    stream("t6wr", 1);
    drive(1, 0, 1, 0, 32'h80, 0, 0, JUNK);
    run_cycle("t6br", mk(32'h0, 1, 32'h0, NOP, 0, 1));
    drive(0, 0, 0, 0, 0, 0, 0, JUNK);
    run_cycle("t6rst", mk(32'h80, 0, 32'h0, NOP, 0, 0));
    run_cycle("t6rs2", mk(32'h0, 0, 32'h0, NOP, 0, 0));
    pc = 32'h0;
    stream("t6s", 2);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
